sd_command_sequencer: RTL and testbench
=======================================

# sd_command_sequencer

Command-level controller for the SPI SD-card target path: consumes each fully decoded command (index plus 32-bit argument) from the SPI receiver, maintains the card initialisation state (idle → ready), and emits the SPI-mode response bytes (R1/R3/R7) to the transmit side over a valid/ready byte handshake. It also owns the block-length register that drives the receiver's data-block size, and sequences single-block read requests toward the backing store.

## Interface
Parameters:
- DEFAULT_BLOCK_LEN, 512: block length after reset, in bytes (1..512).
- OCR_VALUE, 32'h00FF8000: value returned in the R3 payload (CMD58).

Ports (clock and reset first):
- clock  input  1  Single system clock; all state on rising edge.
- reset  input  1  Asynchronous, active-high reset.
- io_CommandValid  input  1  One-cycle strobe: command frame complete.
- io_Command  input  6  Command index, valid with strobe.
- io_CommandArgument  input  32  Argument, valid with strobe.
- io_CommandCrcOk  input  1  Frame CRC check result, valid with strobe.
- io_ResponseByte  output  8  Byte to transmitter.
- io_ResponseValid  output  1  io_ResponseByte is valid.
- io_ResponseReady  input  1  Transmitter accepts byte this cycle.
- io_BlockReadReq  output  1  Single-block read request, level.
- io_BlockAddress  output  32  Block address of the request.
- io_BlockReadDone  input  1  Backing store finished the block.
- io_DataBlockSize  output  10  Current block length (bytes).
- io_CardReady  output  1  Card left idle state (ACMD41 done).
- io_Busy  output  1  Not in S_WAIT_CMD.

## Operation
- FSM states: S_WAIT_CMD (0), S_RESP (1), S_BLOCK (2).
- S_WAIT_CMD: on io_CommandValid, latch command/argument, build response buffer (up to 5 bytes plus a leading 0xFF NCR byte), go S_RESP. io_CommandValid in any other state is dropped with no side effects.
- R1 bits: [0] in_idle = !io_CardReady; [2] illegal command; [3] CRC error; [6] parameter error; [7] always 0.
- App flag: set by accepted CMD55; consumed (cleared) by the following command, whatever it is.
- CMD0: R1; clears io_CardReady, restores DEFAULT_BLOCK_LEN.
- CMD8: R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
- CMD16: arg 1..512 → io_DataBlockSize = arg[9:0]; otherwise parameter error, size unchanged.
- CMD17: R1; if no error bits and io_CardReady, go S_BLOCK after last byte; if not ready, R1 = illegal.
- CMD55: R1. ACMD41 (CMD41 with app flag): sets io_CardReady, R1 = 0x00. CMD41 without app flag: illegal.
- CMD58: R3 = R1, OCR_VALUE MSB first.
- Any other index: R1 with illegal bit set.
- S_BLOCK: io_BlockReadReq = 1, io_BlockAddress = latched arg, held until io_BlockReadDone; then S_WAIT_CMD.

## Timing
- Reset values: io_ResponseValid 0, io_ResponseByte 8'hFF, io_BlockReadReq 0, io_BlockAddress 0, io_DataBlockSize DEFAULT_BLOCK_LEN, io_CardReady 0, io_Busy 0, app flag 0, state S_WAIT_CMD.
- io_CommandValid at cycle N → io_ResponseValid high from N+1, first byte 0xFF (NCR).
- Byte advances on io_ResponseValid && io_ResponseReady; byte/valid held stable while ready is low. The last byte's handshake returns to S_WAIT_CMD (or enters S_BLOCK) next cycle; io_ResponseValid low that cycle.
- io_BlockReadDone in the same cycle as entry to S_BLOCK counts; io_BlockReadReq drops the cycle after io_BlockReadDone. io_BlockReadDone outside S_BLOCK is ignored.
- State updates (io_CardReady, io_DataBlockSize) take effect the cycle after the strobe.
- Asserting reset mid-response or mid-block immediately (asynchronously) returns all outputs to reset values; the in-flight response is abandoned.

## Configuration
- SD_CRC_CHECK_EN defined: io_CommandCrcOk = 0 sets R1 bit 3. The command has no other effect (no state change, no block read, app flag cleared). Response is R1 only, even for CMD8/CMD58.
- Undefined: io_CommandCrcOk ignored; bit 3 always 0.

## Test plan
- Reset, then CMD0 arg 0 with ready held high → bytes 0xFF, 0x01; io_CardReady 0; io_Busy low after the 2nd handshake.
- CMD8 arg 0x000001AA → 0xFF, 0x01, 0x00, 0x00, 0x01, 0xAA.
- CMD55 then CMD41 → responses 0xFF,0x01 then 0xFF,0x00; io_CardReady 1. CMD41 alone after reset → 0xFF, 0x05.
- Ready: CMD16 arg 2048 → 0xFF, 0x40, size stays 512. CMD16 arg 128 → 0xFF, 0x00, io_DataBlockSize 128. CMD17 arg 123 → 0xFF, 0x00, then io_BlockReadReq with address 123 until io_BlockReadDone pulses 5 cycles later.
- io_ResponseReady toggled 1-0-0-1 during CMD58 → 0xFF, 0x00, 0x00, 0xFF, 0x80, 0x00, each held while stalled. A strobe during the response is dropped.
- With SD_CRC_CHECK_EN, CMD16 arg 64 with io_CommandCrcOk 0 → 0xFF, 0x08, size unchanged. Reset asserted mid-CMD8 → io_ResponseValid 0, byte 0xFF immediately.

Source files
------------

// File: rtl/sd_command_sequencer.sv
// sd_command_sequencer: command-level controller for the SPI SD-card target.
// Accepts decoded command frames, tracks card init state (idle -> ready),
// streams R1/R3/R7 response bytes over a valid/ready handshake, owns the
// block-length register, and issues single-block read requests.
// Optional feature macro: SD_CRC_CHECK_EN (frame CRC errors reported in R1
// bit 3 and the command is otherwise suppressed).
module sd_command_sequencer #(
    parameter int          DEFAULT_BLOCK_LEN = 512,
    parameter logic [31:0] OCR_VALUE         = 32'h00FF8000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_CommandValid,
    input  logic [5:0]  io_Command,
    input  logic [31:0] io_CommandArgument,
    input  logic        io_CommandCrcOk,
    output logic [7:0]  io_ResponseByte,
    output logic        io_ResponseValid,
    input  logic        io_ResponseReady,
    output logic        io_BlockReadReq,
    output logic [31:0] io_BlockAddress,
    input  logic        io_BlockReadDone,
    output logic [9:0]  io_DataBlockSize,
    output logic        io_CardReady,
    output logic        io_Busy
);

    typedef enum logic [1:0] {
        S_WAIT_CMD = 2'd0,
        S_RESP     = 2'd1,
        S_BLOCK    = 2'd2
    } state_t;

    localparam logic [9:0] DEFAULT_SIZE = 10'(DEFAULT_BLOCK_LEN);

    state_t      state_q, state_d;
    logic [7:0]  buf_q [6];
    logic [7:0]  buf_d [6];
    logic [2:0]  len_q, len_d;       // number of bytes in the response
    logic [2:0]  idx_q, idx_d;       // byte currently presented
    logic        go_block_q, go_block_d;
    logic        card_ready_q, card_ready_d;
    logic        app_q, app_d;
    logic [9:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;

    // Per-command decode results
    logic        illegal;
    logic        param_err;
    logic        crc_err;
    logic        long_resp;
    logic [31:0] payload;
    logic [7:0]  r1;

    // State and data registers; everything returns to idle values on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_WAIT_CMD;
            for (int i = 0; i < 6; i++) buf_q[i] <= 8'hFF;
            len_q        <= 3'd0;
            idx_q        <= 3'd0;
            go_block_q   <= 1'b0;
            card_ready_q <= 1'b0;
            app_q        <= 1'b0;
            size_q       <= DEFAULT_SIZE;
            addr_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            go_block_q   <= go_block_d;
            card_ready_q <= card_ready_d;
            app_q        <= app_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
        end
    end

    // Next-state logic: command decode, response build, byte sequencing
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        len_d        = len_q;
        idx_d        = idx_q;
        go_block_d   = go_block_q;
        card_ready_d = card_ready_q;
        app_d        = app_q;
        size_d       = size_q;
        addr_d       = addr_q;
        illegal      = 1'b0;
        param_err    = 1'b0;
        crc_err      = 1'b0;
        long_resp    = 1'b0;
        payload      = 32'd0;
        r1           = 8'h00;

        case (state_q)
            S_WAIT_CMD: begin
                if (io_CommandValid) begin
                    addr_d     = io_CommandArgument;
                    app_d      = 1'b0;   // app flag is consumed by any command
                    idx_d      = 3'd0;
                    go_block_d = 1'b0;
                    state_d    = S_RESP;
`ifdef SD_CRC_CHECK_EN
                    crc_err = !io_CommandCrcOk;
`endif
                    if (!crc_err) begin
                        case (io_Command)
                            6'd0: begin
                                card_ready_d = 1'b0;
                                size_d       = DEFAULT_SIZE;
                            end
                            6'd8: begin
                                long_resp = 1'b1;
                                payload   = {16'h0000, 4'h0, io_CommandArgument[11:8],
                                             io_CommandArgument[7:0]};
                            end
                            6'd16: begin
                                if (io_CommandArgument >= 32'd1 && io_CommandArgument <= 32'd512)
                                    size_d = io_CommandArgument[9:0];
                                else
                                    param_err = 1'b1;
                            end
                            6'd17: begin
                                if (card_ready_q) go_block_d = 1'b1;
                                else              illegal    = 1'b1;
                            end
                            6'd41: begin
                                if (app_q) card_ready_d = 1'b1;
                                else       illegal      = 1'b1;
                            end
                            6'd55: app_d = 1'b1;
                            6'd58: begin
                                long_resp = 1'b1;
                                payload   = OCR_VALUE;
                            end
                            default: illegal = 1'b1;
                        endcase
                    end
                    // in_idle reflects the state the command leaves the card in
                    r1 = {1'b0, param_err, 2'b00, crc_err, illegal, 1'b0, !card_ready_d};
                    buf_d[0] = 8'hFF;            // NCR filler byte
                    buf_d[1] = r1;
                    buf_d[2] = payload[31:24];
                    buf_d[3] = payload[23:16];
                    buf_d[4] = payload[15:8];
                    buf_d[5] = payload[7:0];
                    len_d    = long_resp ? 3'd6 : 3'd2;
                end
            end
            S_RESP: begin
                if (io_ResponseReady) begin
                    if (idx_q == len_q - 3'd1) begin
                        idx_d   = 3'd0;
                        state_d = go_block_q ? S_BLOCK : S_WAIT_CMD;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_BLOCK: begin
                if (io_BlockReadDone) begin
                    state_d    = S_WAIT_CMD;
                    go_block_d = 1'b0;
                end
            end
            default: state_d = S_WAIT_CMD;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        io_ResponseValid = (state_q == S_RESP);
        io_ResponseByte  = (state_q == S_RESP) ? buf_q[idx_q] : 8'hFF;
        io_BlockReadReq  = (state_q == S_BLOCK);
        io_BlockAddress  = (state_q == S_BLOCK) ? addr_q : 32'd0;
        io_DataBlockSize = size_q;
        io_CardReady     = card_ready_q;
        io_Busy          = (state_q != S_WAIT_CMD);
    end

endmodule

// File: tb/tb_sd_command_sequencer.sv
// Directed testbench for sd_command_sequencer.
module tb_sd_command_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_CommandValid = 1'b0;
    logic [5:0]  io_Command = 6'd0;
    logic [31:0] io_CommandArgument = 32'd0;
    logic        io_CommandCrcOk = 1'b1;
    logic [7:0]  io_ResponseByte;
    logic        io_ResponseValid;
    logic        io_ResponseReady = 1'b0;
    logic        io_BlockReadReq;
    logic [31:0] io_BlockAddress;
    logic        io_BlockReadDone = 1'b0;
    logic [9:0]  io_DataBlockSize;
    logic        io_CardReady;
    logic        io_Busy;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] got [6];
    logic [7:0] exp_b [6];

    sd_command_sequencer dut (
        .clock              (clock),
        .reset              (reset),
        .io_CommandValid    (io_CommandValid),
        .io_Command         (io_Command),
        .io_CommandArgument (io_CommandArgument),
        .io_CommandCrcOk    (io_CommandCrcOk),
        .io_ResponseByte    (io_ResponseByte),
        .io_ResponseValid   (io_ResponseValid),
        .io_ResponseReady   (io_ResponseReady),
        .io_BlockReadReq    (io_BlockReadReq),
        .io_BlockAddress    (io_BlockAddress),
        .io_BlockReadDone   (io_BlockReadDone),
        .io_DataBlockSize   (io_DataBlockSize),
        .io_CardReady       (io_CardReady),
        .io_Busy            (io_Busy)
    );

    always #5 clock = ~clock;

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse one command strobe; returns one cycle after the accepting edge
    task automatic send_cmd(input logic [5:0] cmd, input logic [31:0] arg, input logic crc_ok);
        io_Command         = cmd;
        io_CommandArgument = arg;
        io_CommandCrcOk    = crc_ok;
        io_CommandValid    = 1'b1;
        tick();
        io_CommandValid    = 1'b0;
        io_CommandCrcOk    = 1'b1;
    endtask

    // Collect n bytes with ready held high; a byte that never shows up is left as X
    task automatic get_resp(input int n);
        io_ResponseReady = 1'b1;
        for (int i = 0; i < n; i++) begin
            int cnt = 0;
            while (!io_ResponseValid && cnt < 20) begin
                tick();
                cnt++;
            end
            got[i] = io_ResponseValid ? io_ResponseByte : 8'hxx;
            tick();
        end
        io_ResponseReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        vectors++; if (io_ResponseValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", io_ResponseValid); end
        vectors++; if (io_ResponseByte !== 8'hFF) begin miscompares++; $display("FAIL reset_byte: got %h expected ff", io_ResponseByte); end
        vectors++; if (io_BlockReadReq !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", io_BlockReadReq); end
        vectors++; if (io_BlockAddress !== 32'd0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", io_BlockAddress); end
        vectors++; if (io_DataBlockSize !== 10'd512) begin miscompares++; $display("FAIL reset_size: got %0d expected 512", io_DataBlockSize); end
        vectors++; if (io_CardReady !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", io_CardReady); end
        vectors++; if (io_Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", io_Busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cmd0();
        send_cmd(6'd0, 32'd0, 1'b1);
        vectors++; if (io_Busy !== 1'b1) begin miscompares++; $display("FAIL cmd0_busy: got %b expected 1", io_Busy); end
        get_resp(2);
        exp_b[0] = 8'hFF; exp_b[1] = 8'h01;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (got[i] !== exp_b[i]) begin miscompares++; $display("FAIL cmd0_byte%0d: got %h expected %h", i, got[i], exp_b[i]); end
        end
        vectors++; if (io_Busy !== 1'b0) begin miscompares++; $display("FAIL cmd0_idle_busy: got %b expected 0", io_Busy); end
        vectors++; if (io_ResponseValid !== 1'b0) begin miscompares++; $display("FAIL cmd0_idle_valid: got %b expected 0", io_ResponseValid); end
        vectors++; if (io_CardReady !== 1'b0) begin miscompares++; $display("FAIL cmd0_ready: got %b expected 0", io_CardReady); end
    endtask

    task automatic test_cmd8();
        send_cmd(6'd8, 32'h000001AA, 1'b1);
        get_resp(6);
        exp_b[0] = 8'hFF; exp_b[1] = 8'h01; exp_b[2] = 8'h00;
        exp_b[3] = 8'h00; exp_b[4] = 8'h01; exp_b[5] = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            vectors++; if (got[i] !== exp_b[i]) begin miscompares++; $display("FAIL cmd8_byte%0d: got %h expected %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_cmd41_no_app();
        send_cmd(6'd41, 32'd0, 1'b1);
        get_resp(2);
        vectors++; if (got[0] !== 8'hFF) begin miscompares++; $display("FAIL cmd41_ncr: got %h expected ff", got[0]); end
        vectors++; if (got[1] !== 8'h05) begin miscompares++; $display("FAIL cmd41_r1: got %h expected 05", got[1]); end
        vectors++; if (io_CardReady !== 1'b0) begin miscompares++; $display("FAIL cmd41_ready: got %b expected 0", io_CardReady); end
    endtask

    task automatic test_acmd41();
        send_cmd(6'd55, 32'd0, 1'b1);
        get_resp(2);
        vectors++; if (got[1] !== 8'h01) begin miscompares++; $display("FAIL cmd55_r1: got %h expected 01", got[1]); end
        send_cmd(6'd41, 32'h40000000, 1'b1);
        get_resp(2);
        vectors++; if (got[0] !== 8'hFF) begin miscompares++; $display("FAIL acmd41_ncr: got %h expected ff", got[0]); end
        vectors++; if (got[1] !== 8'h00) begin miscompares++; $display("FAIL acmd41_r1: got %h expected 00", got[1]); end
        vectors++; if (io_CardReady !== 1'b1) begin miscompares++; $display("FAIL acmd41_ready: got %b expected 1", io_CardReady); end
    endtask

    task automatic test_cmd16();
        send_cmd(6'd16, 32'd2048, 1'b1);
        get_resp(2);
        vectors++; if (got[1] !== 8'h40) begin miscompares++; $display("FAIL cmd16_big_r1: got %h expected 40", got[1]); end
        vectors++; if (io_DataBlockSize !== 10'd512) begin miscompares++; $display("FAIL cmd16_big_size: got %0d expected 512", io_DataBlockSize); end
        send_cmd(6'd16, 32'd128, 1'b1);
        vectors++; if (io_DataBlockSize !== 10'd128) begin miscompares++; $display("FAIL cmd16_size_early: got %0d expected 128", io_DataBlockSize); end
        get_resp(2);
        vectors++; if (got[1] !== 8'h00) begin miscompares++; $display("FAIL cmd16_r1: got %h expected 00", got[1]); end
        vectors++; if (io_DataBlockSize !== 10'd128) begin miscompares++; $display("FAIL cmd16_size: got %0d expected 128", io_DataBlockSize); end
    endtask

    task automatic test_cmd17_block();
        send_cmd(6'd17, 32'd123, 1'b1);
        get_resp(2);
        vectors++; if (got[0] !== 8'hFF) begin miscompares++; $display("FAIL cmd17_ncr: got %h expected ff", got[0]); end
        vectors++; if (got[1] !== 8'h00) begin miscompares++; $display("FAIL cmd17_r1: got %h expected 00", got[1]); end
        for (int c = 0; c < 5; c++) begin
            vectors++; if (io_BlockReadReq !== 1'b1) begin miscompares++; $display("FAIL blk_req_c%0d: got %b expected 1", c, io_BlockReadReq); end
            vectors++; if (io_BlockAddress !== 32'd123) begin miscompares++; $display("FAIL blk_addr_c%0d: got %0d expected 123", c, io_BlockAddress); end
            if (c == 4) io_BlockReadDone = 1'b1;
            tick();
        end
        io_BlockReadDone = 1'b0;
        vectors++; if (io_BlockReadReq !== 1'b0) begin miscompares++; $display("FAIL blk_req_drop: got %b expected 0", io_BlockReadReq); end
        vectors++; if (io_Busy !== 1'b0) begin miscompares++; $display("FAIL blk_busy_drop: got %b expected 0", io_Busy); end
    endtask

    task automatic test_stall_cmd58();
        send_cmd(6'd58, 32'd0, 1'b1);
        io_ResponseReady = 1'b1;
        vectors++; if (io_ResponseByte !== 8'hFF) begin miscompares++; $display("FAIL c58_b0: got %h expected ff", io_ResponseByte); end
        tick();
        io_ResponseReady = 1'b0;
        vectors++; if (io_ResponseByte !== 8'h00) begin miscompares++; $display("FAIL c58_b1: got %h expected 00", io_ResponseByte); end
        // A strobe for CMD0 mid-response must be dropped
        io_Command = 6'd0; io_CommandArgument = 32'd0; io_CommandValid = 1'b1;
        tick();
        io_CommandValid = 1'b0;
        vectors++; if (io_ResponseByte !== 8'h00 || io_ResponseValid !== 1'b1) begin miscompares++; $display("FAIL c58_hold1: got %h/%b expected 00/1", io_ResponseByte, io_ResponseValid); end
        tick();
        vectors++; if (io_ResponseByte !== 8'h00 || io_ResponseValid !== 1'b1) begin miscompares++; $display("FAIL c58_hold2: got %h/%b expected 00/1", io_ResponseByte, io_ResponseValid); end
        io_ResponseReady = 1'b1;
        tick();
        get_resp(4);
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h80; exp_b[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (got[i] !== exp_b[i]) begin miscompares++; $display("FAIL c58_ocr%0d: got %h expected %h", i, got[i], exp_b[i]); end
        end
        vectors++; if (io_Busy !== 1'b0) begin miscompares++; $display("FAIL c58_busy: got %b expected 0", io_Busy); end
        vectors++; if (io_CardReady !== 1'b1) begin miscompares++; $display("FAIL c58_dropped_strobe: got %b expected 1", io_CardReady); end
    endtask

    task automatic test_crc();
`ifdef SD_CRC_CHECK_EN
        send_cmd(6'd16, 32'd64, 1'b0);
        get_resp(2);
        vectors++; if (got[0] !== 8'hFF) begin miscompares++; $display("FAIL crc_ncr: got %h expected ff", got[0]); end
        vectors++; if (got[1] !== 8'h08) begin miscompares++; $display("FAIL crc_r1: got %h expected 08", got[1]); end
        vectors++; if (io_DataBlockSize !== 10'd128) begin miscompares++; $display("FAIL crc_size: got %0d expected 128", io_DataBlockSize); end
`else
        send_cmd(6'd16, 32'd64, 1'b0);
        get_resp(2);
        vectors++; if (got[1] !== 8'h00) begin miscompares++; $display("FAIL nocrc_r1: got %h expected 00", got[1]); end
        vectors++; if (io_DataBlockSize !== 10'd64) begin miscompares++; $display("FAIL nocrc_size: got %0d expected 64", io_DataBlockSize); end
        send_cmd(6'd16, 32'd128, 1'b1);
        get_resp(2);
`endif
    endtask

    task automatic test_cmd0_restore();
        send_cmd(6'd0, 32'd0, 1'b1);
        get_resp(2);
        vectors++; if (got[1] !== 8'h01) begin miscompares++; $display("FAIL cmd0r_r1: got %h expected 01", got[1]); end
        vectors++; if (io_DataBlockSize !== 10'd512) begin miscompares++; $display("FAIL cmd0r_size: got %0d expected 512", io_DataBlockSize); end
        vectors++; if (io_CardReady !== 1'b0) begin miscompares++; $display("FAIL cmd0r_ready: got %b expected 0", io_CardReady); end
    endtask

    task automatic test_reset_mid();
        send_cmd(6'd8, 32'h000001AA, 1'b1);
        io_ResponseReady = 1'b1;
        tick(); tick();
        io_ResponseReady = 1'b0;
        vectors++; if (io_ResponseValid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %b expected 1", io_ResponseValid); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (io_ResponseValid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b expected 0", io_ResponseValid); end
        vectors++; if (io_ResponseByte !== 8'hFF) begin miscompares++; $display("FAIL mid_byte: got %h expected ff", io_ResponseByte); end
        vectors++; if (io_Busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b expected 0", io_Busy); end
        tick();
        reset = 1'b0;
        tick();
        send_cmd(6'd55, 32'd0, 1'b1);
        get_resp(2);
        vectors++; if (got[0] !== 8'hFF || got[1] !== 8'h01) begin miscompares++; $display("FAIL mid_after: got %h %h expected ff 01", got[0], got[1]); end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_cmd41_no_app();
        test_acmd41();
        test_cmd16();
        test_cmd17_block();
        test_stall_cmd58();
        test_crc();
        test_cmd0_restore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
